branch_predictor_btb: RTL and testbench



---
 rtl/bp_pkg.sv | 41 ++++
 rtl/bp_sat_counter.sv | 42 ++++
 rtl/branch_predictor_btb.sv | 164 ++++++++++++++++
 tb/tb_branch_predictor_btb.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// ============================================================================
// Module : bp_pkg
// Brief  : Shared widths, counter constants and lookup-result type for the BTB.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bp_pkg;

    localparam int BP_XLEN = 32;

    // Result of an IF-stage lookup, as carried by NPC generation and pipe regs.
    typedef struct packed {
        logic               hit;
        logic               taken;
        logic [BP_XLEN-1:0] npc;
    } bp_lookup_t;

    function automatic int bp_idx_bits(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int bp_tag_bits(input int xlen, input int entries);
        return xlen - $clog2(entries) - 2;
    endfunction

    function automatic int bp_ctr_wnt(input int ctr_bits);
        return (1 << (ctr_bits - 1)) - 1;
    endfunction

    function automatic int bp_ctr_wt(input int ctr_bits);
        return 1 << (ctr_bits - 1);
    endfunction

    function automatic int bp_ctr_max(input int ctr_bits);
        return (1 << ctr_bits) - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bp_sat_counter.sv
// ============================================================================
// Module : bp_sat_counter
// Brief  : Saturating up/down counter with parallel load and async reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_sat_counter #(
    parameter int               WIDTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_count;

    // Simultaneous inc and dec cancel out; load wins over both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= RESET_VAL;
        end else if (load) begin
            r_count <= load_val;
        end else if (inc && !dec && (r_count != CNT_MAX)) begin
            r_count <= r_count + 1'b1;
        end else if (dec && !inc && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/branch_predictor_btb.sv
// ============================================================================
// Module : branch_predictor_btb
// Brief  : Direct-mapped BTB with per-entry saturating direction counters,
//          EX-stage mispredict detection and saturating perf counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_predictor_btb
    import bp_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ENTRIES   = 64,
    parameter int CTR_BITS  = 2,
    parameter int PERF_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XLEN-1:0]      lk_pc,
    output logic                 lk_hit,
    output logic                 lk_taken,
    output logic [XLEN-1:0]      lk_npc,
    input  logic                 up_valid,
    input  logic [XLEN-1:0]      up_pc,
    input  logic                 up_taken,
    input  logic [XLEN-1:0]      up_target,
    input  logic                 up_pred_taken,
    input  logic [XLEN-1:0]      up_pred_npc,
    output logic                 mispredict,
    output logic [XLEN-1:0]      redirect_pc,
    input  logic                 flush_all,
    output logic [PERF_BITS-1:0] perf_lookups,
    output logic [PERF_BITS-1:0] perf_misp
);

    localparam int IDX_BITS = bp_idx_bits(ENTRIES);
    localparam int TAG_BITS = bp_tag_bits(XLEN, ENTRIES);

    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(bp_ctr_wnt(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(bp_ctr_wt(CTR_BITS));

    logic [ENTRIES-1:0]  r_valid;
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [XLEN-1:0]     r_target [ENTRIES];
    logic [CTR_BITS-1:0] w_ctr    [ENTRIES];

    logic [IDX_BITS-1:0] w_lk_idx;
    logic [TAG_BITS-1:0] w_lk_tag;
    logic [IDX_BITS-1:0] w_up_idx;
    logic [TAG_BITS-1:0] w_up_tag;
    logic                w_up_hit;
    logic                w_upd_en;
    logic                w_alloc;
    logic                w_train;
    logic                w_misp;

    assign w_lk_idx = lk_pc[IDX_BITS+1:2];
    assign w_lk_tag = lk_pc[XLEN-1:IDX_BITS+2];
    assign w_up_idx = up_pc[IDX_BITS+1:2];
    assign w_up_tag = up_pc[XLEN-1:IDX_BITS+2];

    // ------------------------------------------------------------------
    // IF-stage lookup: reads pre-update state, no bypass from EX.
    // ------------------------------------------------------------------
    always_comb begin
        lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
        lk_taken = lk_hit && w_ctr[w_lk_idx][CTR_BITS-1];
        lk_npc   = lk_taken ? r_target[w_lk_idx] : lk_pc + XLEN'(4);
    end

    // ------------------------------------------------------------------
    // EX-stage resolution
    // ------------------------------------------------------------------
    assign w_misp = up_valid &&
                    (up_taken ? (!up_pred_taken || (up_pred_npc != up_target))
                              : up_pred_taken);

    assign mispredict  = w_misp;
    assign redirect_pc = up_taken ? up_target : up_pc + XLEN'(4);

    // A flush in the same cycle drops the update entirely.
    assign w_upd_en = up_valid && !flush_all;
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_alloc  = w_upd_en && !w_up_hit && up_taken;
    assign w_train  = w_upd_en && w_up_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (flush_all) begin
            r_valid <= '0;
        end else if (w_alloc) begin
            r_valid[w_up_idx] <= 1'b1;
        end
    end

    // Tag and target carry no reset; they are only meaningful under valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_alloc) begin
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= up_target;
            end else if (w_train && up_taken) begin
                r_target[w_up_idx] <= up_target;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-entry direction counters
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic w_sel;
            assign w_sel = (w_up_idx == IDX_BITS'(gi));

            bp_sat_counter #(
                .WIDTH     (CTR_BITS),
                .RESET_VAL (CTR_WNT)
            ) u_ctr (
                .clk      (clk),
                .rst      (rst),
                .inc      (w_train && w_sel && up_taken),
                .dec      (w_train && w_sel && !up_taken),
                .load     (w_alloc && w_sel),
                .load_val (CTR_WT),
                .count    (w_ctr[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Performance counters: saturate, survive flush, clear on reset.
    // ------------------------------------------------------------------
    bp_sat_counter #(
        .WIDTH     (PERF_BITS),
        .RESET_VAL ('0)
    ) u_perf_lookups (
        .clk      (clk),
        .rst      (rst),
        .inc      (up_valid),
        .dec      (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .count    (perf_lookups)
    );

    bp_sat_counter #(
        .WIDTH     (PERF_BITS),
        .RESET_VAL ('0)
    ) u_perf_misp (
        .clk      (clk),
        .rst      (rst),
        .inc      (w_misp),
        .dec      (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .count    (perf_misp)
    );

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor_btb.sv
// ============================================================================
// Module : tb_branch_predictor_btb
// Brief  : Directed self-checking bench for branch_predictor_btb.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor_btb;

    logic        clk;
    logic        rst;
    logic [31:0] lk_pc;
    logic        lk_hit;
    logic        lk_taken;
    logic [31:0] lk_npc;
    logic        up_valid;
    logic [31:0] up_pc;
    logic        up_taken;
    logic [31:0] up_target;
    logic        up_pred_taken;
    logic [31:0] up_pred_npc;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        flush_all;
    logic [31:0] perf_lookups;
    logic [31:0] perf_misp;

    int checks   = 0;
    int failures = 0;

    branch_predictor_btb #(
        .XLEN      (32),
        .ENTRIES   (64),
        .CTR_BITS  (2),
        .PERF_BITS (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .lk_pc         (lk_pc),
        .lk_hit        (lk_hit),
        .lk_taken      (lk_taken),
        .lk_npc        (lk_npc),
        .up_valid      (up_valid),
        .up_pc         (up_pc),
        .up_taken      (up_taken),
        .up_target     (up_target),
        .up_pred_taken (up_pred_taken),
        .up_pred_npc   (up_pred_npc),
        .mispredict    (mispredict),
        .redirect_pc   (redirect_pc),
        .flush_all     (flush_all),
        .perf_lookups  (perf_lookups),
        .perf_misp     (perf_misp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_up(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                            input logic ptk, input logic [31:0] pnpc);
        up_valid      = 1'b1;
        up_pc         = pc;
        up_taken      = tk;
        up_target     = tgt;
        up_pred_taken = ptk;
        up_pred_npc   = pnpc;
    endtask

    task automatic test_reset();
        rst = 1'b1; lk_pc = 32'h0; up_valid = 1'b0; up_pc = 32'h0; up_taken = 1'b0;
        up_target = 32'h0; up_pred_taken = 1'b0; up_pred_npc = 32'h0; flush_all = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        lk_pc = 32'h100;
        #1;
        checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%0b exp=0", lk_hit); end
        checks++; if (lk_taken !== 1'b0) begin failures++; $display("FAIL reset_taken got=%0b exp=0", lk_taken); end
        checks++; if (lk_npc !== 32'h104) begin failures++; $display("FAIL reset_npc got=%h exp=104", lk_npc); end
        checks++; if (perf_lookups !== 32'd0) begin failures++; $display("FAIL reset_perf_lookups got=%0d exp=0", perf_lookups); end
        checks++; if (perf_misp !== 32'd0) begin failures++; $display("FAIL reset_perf_misp got=%0d exp=0", perf_misp); end
    endtask

    task automatic test_alloc();
        lk_pc = 32'h100;
        drive_up(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        #1;
        checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL alloc_misp got=%0b exp=1", mispredict); end
        checks++; if (redirect_pc !== 32'h80) begin failures++; $display("FAIL alloc_redirect got=%h exp=80", redirect_pc); end
        checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL alloc_no_bypass got=%0b exp=0", lk_hit); end
        tick();
        up_valid = 1'b0;
        #1;
        checks++; if (lk_hit !== 1'b1) begin failures++; $display("FAIL alloc_hit got=%0b exp=1", lk_hit); end
        checks++; if (lk_taken !== 1'b1) begin failures++; $display("FAIL alloc_taken got=%0b exp=1", lk_taken); end
        checks++; if (lk_npc !== 32'h80) begin failures++; $display("FAIL alloc_npc got=%h exp=80", lk_npc); end
        checks++; if (perf_misp !== 32'd1) begin failures++; $display("FAIL alloc_perf_misp got=%0d exp=1", perf_misp); end
        checks++; if (perf_lookups !== 32'd1) begin failures++; $display("FAIL alloc_perf_lookups got=%0d exp=1", perf_lookups); end
    endtask

    task automatic test_alias();
        lk_pc = 32'h200;
        #1;
        checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL alias_miss got=%0b exp=0", lk_hit); end
        drive_up(32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
        tick();
        up_valid = 1'b0;
        lk_pc = 32'h100;
        #1;
        checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL alias_evicted got=%0b exp=0", lk_hit); end
        lk_pc = 32'h200;
        #1;
        checks++; if (lk_npc !== 32'h300) begin failures++; $display("FAIL alias_new_npc got=%h exp=300", lk_npc); end
    endtask

    task automatic test_wrap();
        lk_pc = 32'hFFFF_FFFC;
        drive_up(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        checks++; if (lk_npc !== 32'h0) begin failures++; $display("FAIL wrap_lk_npc got=%h exp=0", lk_npc); end
        checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL wrap_misp got=%0b exp=0", mispredict); end
        checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL wrap_redirect got=%h exp=0", redirect_pc); end
        tick();
        up_valid = 1'b0;
        #1;
        checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL wrap_no_alloc got=%0b exp=0", lk_hit); end
    endtask

    task automatic test_hysteresis();
        lk_pc = 32'h100;
        drive_up(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        tick();
        drive_up(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        #1;
        checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL hyst_correct_misp got=%0b exp=0", mispredict); end
        tick();
        tick();
        drive_up(32'h100, 1'b0, 32'hDEAD0, 1'b1, 32'h80);
        #1;
        checks++; if (redirect_pc !== 32'h104) begin failures++; $display("FAIL hyst_nt_redirect got=%h exp=104", redirect_pc); end
        checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL hyst_nt_misp got=%0b exp=1", mispredict); end
        tick();
        up_valid = 1'b0;
        #1;
        checks++; if (lk_taken !== 1'b1 || lk_npc !== 32'h80) begin failures++; $display("FAIL hyst_ctr2 got taken=%0b npc=%h exp taken=1 npc=80", lk_taken, lk_npc); end
        drive_up(32'h100, 1'b0, 32'hDEAD0, 1'b1, 32'h80);
        tick();
        up_valid = 1'b0;
        #1;
        checks++; if (lk_hit !== 1'b1 || lk_taken !== 1'b0 || lk_npc !== 32'h104) begin failures++; $display("FAIL hyst_ctr1 got hit=%0b taken=%0b npc=%h exp 1 0 104", lk_hit, lk_taken, lk_npc); end
        drive_up(32'h100, 1'b1, 32'h80, 1'b1, 32'h84);
        #1;
        checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL hyst_wrong_target got=%0b exp=1", mispredict); end
        tick();
        up_valid = 1'b0;
        #1;
        checks++; if (lk_taken !== 1'b1 || lk_npc !== 32'h80) begin failures++; $display("FAIL hyst_back_to_2 got taken=%0b npc=%h exp 1 80", lk_taken, lk_npc); end
        drive_up(32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
        #1;
        checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL hyst_pred_nt_ok got=%0b exp=0", mispredict); end
        tick();
        up_valid = 1'b0;
        #1;
        checks++; if (lk_taken !== 1'b0 || lk_hit !== 1'b1) begin failures++; $display("FAIL hyst_final got hit=%0b taken=%0b exp 1 0", lk_hit, lk_taken); end
        checks++; if (perf_lookups !== 32'd10) begin failures++; $display("FAIL hyst_perf_lookups got=%0d exp=10", perf_lookups); end
        checks++; if (perf_misp !== 32'd6) begin failures++; $display("FAIL hyst_perf_misp got=%0d exp=6", perf_misp); end
    endtask

    task automatic test_flush();
        drive_up(32'h104, 1'b1, 32'h500, 1'b0, 32'h108);
        tick();
        up_valid = 1'b0;
        lk_pc = 32'h104;
        #1;
        checks++; if (lk_hit !== 1'b1 || lk_npc !== 32'h500) begin failures++; $display("FAIL flush_pre got hit=%0b npc=%h exp 1 500", lk_hit, lk_npc); end
        flush_all = 1'b1;
        drive_up(32'h400, 1'b1, 32'h440, 1'b0, 32'h404);
        tick();
        flush_all = 1'b0;
        up_valid = 1'b0;
        lk_pc = 32'h100;
        #1;
        checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL flush_100 got=%0b exp=0", lk_hit); end
        lk_pc = 32'h400;
        #1;
        checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL flush_400_dropped got=%0b exp=0", lk_hit); end
        lk_pc = 32'h104;
        #1;
        checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL flush_104 got=%0b exp=0", lk_hit); end
        checks++; if (perf_lookups !== 32'd12) begin failures++; $display("FAIL flush_perf_lookups got=%0d exp=12", perf_lookups); end
        checks++; if (perf_misp !== 32'd8) begin failures++; $display("FAIL flush_perf_misp got=%0d exp=8", perf_misp); end
    endtask

    task automatic test_async_reset();
        drive_up(32'h108, 1'b1, 32'h600, 1'b0, 32'h10C);
        tick();
        up_valid = 1'b0;
        lk_pc = 32'h108;
        #1;
        checks++; if (lk_hit !== 1'b1) begin failures++; $display("FAIL arst_pre_hit got=%0b exp=1", lk_hit); end
        #2 rst = 1'b1;
        #1;
        checks++; if (lk_hit !== 1'b0 || lk_taken !== 1'b0) begin failures++; $display("FAIL arst_hit got hit=%0b taken=%0b exp 0 0", lk_hit, lk_taken); end
        checks++; if (lk_npc !== 32'h10C) begin failures++; $display("FAIL arst_npc got=%h exp=10c", lk_npc); end
        checks++; if (perf_lookups !== 32'd0 || perf_misp !== 32'd0) begin failures++; $display("FAIL arst_perf got=%0d/%0d exp=0/0", perf_lookups, perf_misp); end
        drive_up(32'h108, 1'b1, 32'h600, 1'b0, 32'h10C);
        #1;
        checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h600) begin failures++; $display("FAIL arst_misp got=%0b/%h exp=1/600", mispredict, redirect_pc); end
        tick();
        up_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL arst_no_update got=%0b exp=0", lk_hit); end
        checks++; if (perf_lookups !== 32'd0) begin failures++; $display("FAIL arst_perf_hold got=%0d exp=0", perf_lookups); end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_alias();
        test_wrap();
        test_hysteresis();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
